shift_add_multiplier: RTL

- Sequential unsigned shift-add multiplier: one operand pair per start pulse, one partial-product bit per clock.
- Sits directly upstream of the datapath's generic load/clear register.
- Drives that register's dataIn, load and clear pins, so the downstream register captures each finished product without extra glue logic.
- Controller FSM plus iteration counter plus accumulator/multiplier shift datapath.

---
 rtl/mult_pkg.sv | 28 ++
 rtl/mult_controller.sv | 91 +++++++++
 rtl/shift_add_multiplier.sv | 103 ++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_pkg
// Description : Shared state encoding, counter sizing and defaults for the
//               shift-add multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        CALC = ST_CALC,
        DONE = ST_DONE
    } state_e;

    // Counter must reach WIDTH, hence WIDTH+1 distinct values.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult_controller.sv
`default_nettype none
// ============================================================================
// Module      : mult_controller
// Description : IDLE/CALC/DONE sequencer and iteration counter; issues
//               capture/step/finish/flush strobes to the datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_controller
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    input  logic clear_i,
    output logic capture_o,
    output logic step_o,
    output logic finish_o,
    output logic flush_o,
    output logic busy_o
);

    localparam int                 CNT_W = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0]   LAST  = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               busy_q,  busy_d;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        busy_d    = busy_q;
        capture_o = 1'b0;
        step_o    = 1'b0;
        finish_o  = 1'b0;
        flush_o   = 1'b0;

        if (clear_i) begin
            // Abort dominates everything, including a coincident start.
            flush_o = 1'b1;
            state_d = IDLE;
            count_d = '0;
            busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        capture_o = 1'b1;
                        count_d   = '0;
                        busy_d    = 1'b1;
                        state_d   = CALC;
                    end
                end
                CALC: begin
                    step_o  = 1'b1;
                    count_d = count_q + CNT_W'(1);
                    if (count_q == LAST) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    finish_o = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            busy_q  <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule
`default_nettype wire

// File: rtl/shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : shift_add_multiplier
// Description : Sequential unsigned shift-add multiplier whose outputs drive a
//               downstream load/clear register directly.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 clear,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic                 load_out,
    output logic                 clear_out
);

    logic w_capture, w_step, w_finish, w_flush;

    logic [WIDTH-1:0]   m_q,       m_d;
    logic [WIDTH:0]     acc_q,     acc_d;
    logic [WIDTH-1:0]   q_q,       q_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               done_q;
    logic               load_q;
    logic               clear_out_q;
    logic [WIDTH:0]     w_sum;

    mult_controller #(
        .WIDTH (WIDTH)
    ) u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start),
        .clear_i   (clear),
        .capture_o (w_capture),
        .step_o    (w_step),
        .finish_o  (w_finish),
        .flush_o   (w_flush),
        .busy_o    (busy)
    );

    // acc's MSB is zero after every shift, so the sum cannot overflow WIDTH+1.
    assign w_sum = q_q[0] ? (acc_q + {1'b0, m_q}) : acc_q;

    always_comb begin
        m_d       = m_q;
        acc_d     = acc_q;
        q_d       = q_q;
        product_d = product_q;

        if (w_flush) begin
            m_d       = '0;
            acc_d     = '0;
            q_d       = '0;
            product_d = '0;
        end else if (w_capture) begin
            m_d   = a;
            q_d   = b;
            acc_d = '0;
        end else if (w_step) begin
            acc_d = {1'b0, w_sum[WIDTH:1]};
            q_d   = {w_sum[0], q_q[WIDTH-1:1]};
        end else if (w_finish) begin
            product_d = {acc_q[WIDTH-1:0], q_q};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q         <= '0;
            acc_q       <= '0;
            q_q         <= '0;
            product_q   <= '0;
            done_q      <= 1'b0;
            load_q      <= 1'b0;
            clear_out_q <= 1'b0;
        end else begin
            m_q         <= m_d;
            acc_q       <= acc_d;
            q_q         <= q_d;
            product_q   <= product_d;
            done_q      <= w_finish;
            load_q      <= w_finish;
            clear_out_q <= w_flush;
        end
    end

    assign done      = done_q;
    assign load_out  = load_q;
    assign clear_out = clear_out_q;
    assign product   = product_q;

endmodule
`default_nettype wire
